// File: rtl/branch_group_select_pkg.sv
// Shared fetch-group constants and the delay-slot FSM encoding.
// Used by the branch group selector and its priority picker.
package branch_group_select_pkg;

  localparam int DEF_FETCH_W    = 4;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_INST_BYTES = 4;
  localparam int DEF_GROUP_STEP = DEF_FETCH_W * DEF_INST_BYTES;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_WAIT_DS = 1'b1
  } ds_state_e;

  // Index width that stays legal when a group holds a single slot.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/branch_priority_pick.sv
// Lowest-set-bit finder: one-hot, binary index and any-set flag.
// Purely combinational; no handshake.
module branch_priority_pick
  import branch_group_select_pkg::*;
#(
  parameter int W  = 4,
  parameter int IW = idx_width(W)
) (
  input  logic [W-1:0]  eff_i,
  output logic [W-1:0]  onehot_o,
  output logic [IW-1:0] index_o,
  output logic          any_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    onehot_o = '0;
    index_o  = '0;
    any_o    = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (eff_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        index_o     = IW'(i);
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_group_select.sv
// Trims a fetch group at its first predicted-taken branch (+ delay slot) and issues redirects.
// One registered stage, valid/ready; a delay slot in the next group defers the redirect.
module branch_group_select
  import branch_group_select_pkg::*;
#(
  parameter int FETCH_W    = DEF_FETCH_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int INST_BYTES = DEF_INST_BYTES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [ADDR_W-1:0]         in_pc_i,
  input  logic [FETCH_W-1:0]        in_enable_i,
  input  logic [FETCH_W-1:0]        in_pred_take_i,
  input  logic [FETCH_W*ADDR_W-1:0] in_pred_dest_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ADDR_W-1:0]         out_pc_o,
  output logic [FETCH_W-1:0]        out_enable_o,
  output logic [FETCH_W-1:0]        out_first_branch_o,
  output logic                      out_take_o,
  output logic                      out_need_ds_o,
  output logic [ADDR_W-1:0]         out_next_pc_o,
  output logic                      redirect_valid_o,
  output logic [ADDR_W-1:0]         redirect_pc_o
);

  localparam int                IW   = idx_width(FETCH_W);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(FETCH_W * INST_BYTES);

  ds_state_e           r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pending, w_pending_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic [ADDR_W-1:0]   r_out_pc, w_out_pc_nxt;
  logic [FETCH_W-1:0]  r_out_enable, w_out_enable_nxt;
  logic [FETCH_W-1:0]  r_out_fb, w_out_fb_nxt;
  logic                r_out_take, w_out_take_nxt;
  logic                r_out_need_ds, w_out_need_ds_nxt;
  logic [ADDR_W-1:0]   r_out_next_pc, w_out_next_pc_nxt;
  logic                r_redir_vld, w_redir_vld_nxt;
  logic [ADDR_W-1:0]   r_redir_pc, w_redir_pc_nxt;

  logic [FETCH_W-1:0]  w_eff;
  logic [FETCH_W-1:0]  w_onehot;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic                w_last;
  logic [FETCH_W-1:0]  w_mask;
  logic [ADDR_W-1:0]   w_dest;
  logic                w_accept;

  assign w_eff = in_enable_i & in_pred_take_i;

  branch_priority_pick #(
    .W (FETCH_W),
    .IW(IW)
  ) u_pick (
    .eff_i   (w_eff),
    .onehot_o(w_onehot),
    .index_o (w_idx),
    .any_o   (w_any)
  );

  assign w_last     = w_any && (w_idx == IW'(FETCH_W - 1));
  // Keep slots 0..k+1: the branch, everything before it, and its delay slot.
  assign w_mask     = (w_onehot << 1) | w_onehot | (w_onehot - FETCH_W'(1));
  assign in_ready_o = !flush_i && (!r_out_valid || out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o;

  always_comb begin
    w_dest = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (w_onehot[i]) begin
        w_dest = in_pred_dest_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pending_nxt     = r_pending;
    w_out_valid_nxt   = r_out_valid;
    w_out_pc_nxt      = r_out_pc;
    w_out_enable_nxt  = r_out_enable;
    w_out_fb_nxt      = r_out_fb;
    w_out_take_nxt    = r_out_take;
    w_out_need_ds_nxt = r_out_need_ds;
    w_out_next_pc_nxt = r_out_next_pc;
    w_redir_vld_nxt   = 1'b0;
    w_redir_pc_nxt    = r_redir_pc;

    if (flush_i) begin
      w_out_valid_nxt = 1'b0;
      w_state_nxt     = ST_NORMAL;
      w_pending_nxt   = '0;
    end else if (w_accept) begin
      w_out_valid_nxt   = 1'b1;
      w_out_pc_nxt      = in_pc_i;
      w_out_fb_nxt      = '0;
      w_out_take_nxt    = 1'b0;
      w_out_need_ds_nxt = 1'b0;
      if (r_state == ST_WAIT_DS) begin
        // Predictions inside the delay-slot group are deliberately ignored.
        w_out_next_pc_nxt = r_pending;
        if (in_enable_i[0]) begin
          w_out_enable_nxt = FETCH_W'(1);
          w_redir_vld_nxt  = 1'b1;
          w_redir_pc_nxt   = r_pending;
          w_state_nxt      = ST_NORMAL;
        end else begin
          w_out_enable_nxt = '0;
        end
      end else if (!w_any) begin
        w_out_enable_nxt  = in_enable_i;
        w_out_next_pc_nxt = in_pc_i + STEP;
      end else begin
        w_out_fb_nxt      = w_onehot;
        w_out_take_nxt    = 1'b1;
        w_out_next_pc_nxt = w_dest;
        if (w_last) begin
          w_out_enable_nxt  = in_enable_i;
          w_out_need_ds_nxt = 1'b1;
          w_pending_nxt     = w_dest;
          w_state_nxt       = ST_WAIT_DS;
        end else begin
          w_out_enable_nxt = in_enable_i & w_mask;
          w_redir_vld_nxt  = 1'b1;
          w_redir_pc_nxt   = w_dest;
        end
      end
    end else if (out_ready_i) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_NORMAL;
      r_pending     <= '0;
      r_out_valid   <= 1'b0;
      r_out_pc      <= '0;
      r_out_enable  <= '0;
      r_out_fb      <= '0;
      r_out_take    <= 1'b0;
      r_out_need_ds <= 1'b0;
      r_out_next_pc <= '0;
      r_redir_vld   <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pending     <= w_pending_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_pc      <= w_out_pc_nxt;
      r_out_enable  <= w_out_enable_nxt;
      r_out_fb      <= w_out_fb_nxt;
      r_out_take    <= w_out_take_nxt;
      r_out_need_ds <= w_out_need_ds_nxt;
      r_out_next_pc <= w_out_next_pc_nxt;
      r_redir_vld   <= w_redir_vld_nxt;
      r_redir_pc    <= w_redir_pc_nxt;
    end
  end

  assign out_valid_o        = r_out_valid;
  assign out_pc_o           = r_out_pc;
  assign out_enable_o       = r_out_enable;
  assign out_first_branch_o = r_out_fb;
  assign out_take_o         = r_out_take;
  assign out_need_ds_o      = r_out_need_ds;
  assign out_next_pc_o      = r_out_next_pc;
  assign redirect_valid_o   = r_redir_vld;
  assign redirect_pc_o      = r_redir_pc;

endmodule

// File: tb/tb_branch_group_select.sv
// Directed bench for branch_group_select: a driver queues expected groups/redirects,
// independent negedge monitors pop and compare them.
module tb_branch_group_select;

  logic          clk;
  logic          rst;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [31:0]   in_pc_i;
  logic [3:0]    in_enable_i;
  logic [3:0]    in_pred_take_i;
  logic [127:0]  in_pred_dest_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   out_pc_o;
  logic [3:0]    out_enable_o;
  logic [3:0]    out_first_branch_o;
  logic          out_take_o;
  logic          out_need_ds_o;
  logic [31:0]   out_next_pc_o;
  logic          redirect_valid_o;
  logic [31:0]   redirect_pc_o;

  branch_group_select dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .in_pc_i           (in_pc_i),
    .in_enable_i       (in_enable_i),
    .in_pred_take_i    (in_pred_take_i),
    .in_pred_dest_i    (in_pred_dest_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .out_pc_o          (out_pc_o),
    .out_enable_o      (out_enable_o),
    .out_first_branch_o(out_first_branch_o),
    .out_take_o        (out_take_o),
    .out_need_ds_o     (out_need_ds_o),
    .out_next_pc_o     (out_next_pc_o),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  en;
    logic [3:0]  fb;
    logic        take;
    logic        nds;
    logic [31:0] npc;
    bit          chk_npc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] redir_q[$];
  exp_t        mon_e;
  logic [31:0] mon_r;
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] en, input logic [3:0] fb,
                              input logic take, input logic nds, input logic [31:0] npc,
                              input bit chk_npc);
    exp_t e;
    e.pc = pc; e.en = en; e.fb = fb; e.take = take; e.nds = nds; e.npc = npc;
    e.chk_npc = chk_npc;
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] pc, input logic [3:0] en, input logic [3:0] tk,
                      input logic [127:0] dest, input exp_t e, input bit redir,
                      input logic [31:0] rpc);
    bit done;
    done           = 1'b0;
    in_valid_i     = 1'b1;
    in_pc_i        = pc;
    in_enable_i    = en;
    in_pred_take_i = tk;
    in_pred_dest_i = dest;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (in_ready_o) begin
        exp_q.push_back(e);
        if (redir) redir_q.push_back(rpc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pc %h not accepted, required accept within 40 cycles", pc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_group: got pc %h expected no group", out_pc_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grp_pc", out_pc_o, mon_e.pc);
          chk("grp_enable", {28'd0, out_enable_o}, {28'd0, mon_e.en});
          chk("grp_first_branch", {28'd0, out_first_branch_o}, {28'd0, mon_e.fb});
          chk("grp_take", {31'd0, out_take_o}, {31'd0, mon_e.take});
          chk("grp_need_ds", {31'd0, out_need_ds_o}, {31'd0, mon_e.nds});
          if (mon_e.chk_npc) chk("grp_next_pc", out_next_pc_o, mon_e.npc);
        end
      end
      if (redirect_valid_o) begin
        if (redir_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_redirect: got %h expected no redirect", redirect_pc_o);
        end else begin
          mon_r = redir_q.pop_front();
          chk("redirect_pc", redirect_pc_o, mon_r);
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    flush_i        = 1'b0;
    in_valid_i     = 1'b0;
    in_pc_i        = '0;
    in_enable_i    = '0;
    in_pred_take_i = '0;
    in_pred_dest_i = '0;
    out_ready_i    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid_o}, 32'd0);
    chk("rst_enable", {28'd0, out_enable_o}, 32'd0);
    chk("rst_first_branch", {28'd0, out_first_branch_o}, 32'd0);
    chk("rst_take_need_ds", {30'd0, out_take_o, out_need_ds_o}, 32'd0);
    chk("rst_pc", out_pc_o, 32'd0);
    chk("rst_next_pc", out_next_pc_o, 32'd0);
    chk("rst_redirect_pc", redirect_pc_o, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk);
    #1;

    // No taken branch, then an early branch in slot 1 (slot 2 prediction shadowed).
    send(32'hBFC00000, 4'b1111, 4'b0000, 128'd0,
         mk(32'hBFC00000, 4'b1111, 4'b0000, 0, 0, 32'hBFC00010, 1), 0, 32'd0);
    send(32'hBFC00000, 4'b1111, 4'b0110, {32'd0, 32'hBFC00ABC, 32'hBFC00100, 32'd0},
         mk(32'hBFC00000, 4'b0111, 4'b0010, 1, 0, 32'hBFC00100, 1), 1, 32'hBFC00100);

    // Branch in the last slot: redirect waits for the delay-slot group.
    send(32'hBFC00000, 4'b1111, 4'b1000, {32'hBFC00200, 96'd0},
         mk(32'hBFC00000, 4'b1111, 4'b1000, 1, 1, 32'hBFC00200, 1), 0, 32'd0);
    send(32'hBFC00010, 4'b1111, 4'b0110, {32'd0, 32'h11111111, 32'h22222222, 32'd0},
         mk(32'hBFC00010, 4'b0001, 4'b0000, 0, 0, 32'hBFC00200, 1), 1, 32'hBFC00200);

    // Backpressure: output stalls for three cycles, redirect fires exactly once.
    idle(2);
    out_ready_i = 1'b0;
    send(32'hBFC00040, 4'b1111, 4'b0001, {96'd0, 32'hBFC00300},
         mk(32'hBFC00040, 4'b0011, 4'b0001, 1, 0, 32'hBFC00300, 1), 1, 32'hBFC00300);
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("bp_enable", {28'd0, out_enable_o}, 32'h3);
      chk("bp_next_pc", out_next_pc_o, 32'hBFC00300);
      @(posedge clk);
      #1;
    end
    out_ready_i = 1'b1;

    // Flush while waiting for a delay slot: pending redirect must vanish.
    idle(2);
    send(32'hBFC00040, 4'b1111, 4'b1000, {32'hBFC00400, 96'd0},
         mk(32'hBFC00040, 4'b1111, 4'b1000, 1, 1, 32'hBFC00400, 1), 0, 32'd0);
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready_o}, 32'd0);
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    send(32'hBFC00050, 4'b1111, 4'b0000, 128'd0,
         mk(32'hBFC00050, 4'b1111, 4'b0000, 0, 0, 32'hBFC00060, 1), 0, 32'd0);

    // Disabled taken slot, then a WAIT_DS bubble that must not release the redirect.
    send(32'hBFC00060, 4'b1101, 4'b0010, {64'd0, 32'hDEADBEEF, 32'd0},
         mk(32'hBFC00060, 4'b1101, 4'b0000, 0, 0, 32'hBFC00070, 1), 0, 32'd0);
    send(32'hBFC00070, 4'b1111, 4'b1000, {32'hBFC00500, 96'd0},
         mk(32'hBFC00070, 4'b1111, 4'b1000, 1, 1, 32'hBFC00500, 1), 0, 32'd0);
    send(32'hBFC00080, 4'b1110, 4'b0000, 128'd0,
         mk(32'hBFC00080, 4'b0000, 4'b0000, 0, 0, 32'd0, 0), 0, 32'd0);
    send(32'hBFC00080, 4'b1111, 4'b0010, {64'd0, 32'h33333333, 32'd0},
         mk(32'hBFC00080, 4'b0001, 4'b0000, 0, 0, 32'hBFC00500, 1), 1, 32'hBFC00500);

    // Sequential next PC wraps modulo 2^32.
    send(32'hFFFFFFF8, 4'b0011, 4'b0000, 128'd0,
         mk(32'hFFFFFFF8, 4'b0011, 4'b0000, 0, 0, 32'h00000008, 1), 0, 32'd0);

    idle(5);
    chk("groups_drained", exp_q.size(), 32'd0);
    chk("redirects_drained", redir_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
